// File: rtl/contador_descendente_recarga.sv
// Loadable N-bit down-counter/timer: IDLE -> COUNT -> DONE with a one-cycle done pulse.
// Build option AUTO_RELOAD_EN: DONE reloads the last start value and keeps counting periodically.
module contador_descendente_recarga #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         start,
  input  logic         stop,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic         busy_q, done_q;

`ifdef AUTO_RELOAD_EN
  logic [N-1:0] reload_q, reload_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (stop) begin
      // Abort keeps whatever count was reached so it can be inspected.
      state_d = S_IDLE;
    end else if (start) begin
      cnt_d   = load_val;
      state_d = (load_val != ZERO) ? S_COUNT : S_DONE;
`ifdef AUTO_RELOAD_EN
      reload_d = load_val;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_COUNT: begin
          if (en) begin
            if (cnt_q > ONE) begin
              cnt_d = cnt_q - ONE;
            end else begin
              cnt_d   = ZERO;
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
`ifdef AUTO_RELOAD_EN
          cnt_d   = reload_q;
          state_d = (reload_q != ZERO) ? S_COUNT : S_DONE;
`else
          state_d = S_IDLE;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_q <= ZERO;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == S_COUNT);
      done_q  <= (state_d == S_DONE);
`ifdef AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign q    = cnt_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_contador_descendente_recarga.sv
// Directed vector bench for contador_descendente_recarga (N=4); table rows are applied one edge each.
module tb_contador_descendente_recarga;

  localparam int N = 4;

  logic         clk, reset, en, start, stop;
  logic [N-1:0] load_val, q;
  logic         busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  contador_descendente_recarga #(.N(N)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .stop(stop),
    .load_val(load_val), .q(q), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         st;
    logic         en;
    logic         sp;
    logic [N-1:0] lv;
    logic [N-1:0] q;
    logic         b;
    logic         d;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic e, input logic sp, input logic [N-1:0] lv,
                     input logic [N-1:0] eq, input logic eb, input logic ed);
    vec_t v;
    v.st = st; v.en = e; v.sp = sp; v.lv = lv; v.q = eq; v.b = eb; v.d = ed;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [N-1:0] eq, input logic eb, input logic ed);
    n_tests++;
    if (q !== eq || busy !== eb || done !== ed) begin
      n_fail++;
      $display("FAIL %s: got q=%0d busy=%b done=%b, want q=%0d busy=%b done=%b",
               name, q, busy, done, eq, eb, ed);
    end
  endtask

  task automatic drive(input logic st, input logic e, input logic sp, input logic [N-1:0] lv);
    start = st; en = e; stop = sp; load_val = lv;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, '0);
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 check("reset_init", 4'd0, 0, 0);
    step();
    step();
    check("reset_held", 4'd0, 0, 0);
    reset = 1'b1;
    step();
    check("after_release", 4'd0, 0, 0);

    // async reset mid-count, q=5
    drive(1, 0, 0, 4'd5);
    step();
    check("load5", 4'd5, 1, 0);
    drive(0, 1, 0, '0);
    #2 reset = 1'b0;
    #1 check("reset_async_count", 4'd0, 0, 0);
    drive(1, 1, 0, 4'd7);
    step();
    step();
    check("reset_held_start", 4'd0, 0, 0);
    drive(0, 0, 0, '0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("release_idle", 4'd0, 0, 0);

    // reset during DONE kills the pulse
    drive(1, 1, 0, 4'd0);
    step();
    check("done_before_rst", 4'd0, 0, 1);
    drive(0, 0, 0, '0);
    reset = 1'b0;
    #1 check("reset_async_done", 4'd0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    step();

`ifndef AUTO_RELOAD_EN
    // basic countdown of 3
    add(1,1,0, 4'd3, 4'd3,1,0);
    add(0,1,0, 4'd0, 4'd2,1,0);
    add(0,1,0, 4'd0, 4'd1,1,0);
    add(0,1,0, 4'd0, 4'd0,0,1);
    add(0,1,0, 4'd0, 4'd0,0,0);
    add(0,1,0, 4'd0, 4'd0,0,0);
    // en alternating
    add(1,0,0, 4'd3, 4'd3,1,0);
    add(0,1,0, 4'd0, 4'd2,1,0);
    add(0,0,0, 4'd0, 4'd2,1,0);
    add(0,1,0, 4'd0, 4'd1,1,0);
    add(0,0,0, 4'd0, 4'd1,1,0);
    add(0,1,0, 4'd0, 4'd0,0,1);
    add(0,0,0, 4'd0, 4'd0,0,0);
    // zero load goes straight to DONE
    add(1,1,0, 4'd0, 4'd0,0,1);
    add(0,1,0, 4'd0, 4'd0,0,0);
    // restart mid-count, then stop
    add(1,1,0, 4'd4, 4'd4,1,0);
    add(0,1,0, 4'd0, 4'd3,1,0);
    add(0,1,0, 4'd0, 4'd2,1,0);
    add(1,1,0, 4'd9, 4'd9,1,0);
    add(0,1,0, 4'd0, 4'd8,1,0);
    add(0,1,0, 4'd0, 4'd7,1,0);
    add(0,1,0, 4'd0, 4'd6,1,0);
    add(0,1,1, 4'd0, 4'd6,0,0);
    add(0,1,0, 4'd0, 4'd6,0,0);
    add(1,1,1, 4'd5, 4'd6,0,0);
    // full-scale load
    add(1,0,0, 4'd15, 4'd15,1,0);
    add(0,1,0, 4'd0,  4'd14,1,0);
    // start while in DONE
    add(1,1,0, 4'd2, 4'd2,1,0);
    add(0,1,0, 4'd0, 4'd1,1,0);
    add(0,1,0, 4'd0, 4'd0,0,1);
    add(1,1,0, 4'd1, 4'd1,1,0);
    add(0,1,0, 4'd0, 4'd0,0,1);
    add(0,0,0, 4'd0, 4'd0,0,0);
    // stop while in DONE
    add(1,0,0, 4'd1, 4'd1,1,0);
    add(0,1,0, 4'd0, 4'd0,0,1);
    add(0,0,1, 4'd0, 4'd0,0,0);
    // restart with zero while counting
    add(1,0,0, 4'd3, 4'd3,1,0);
    add(1,0,0, 4'd0, 4'd0,0,1);
    add(0,0,0, 4'd0, 4'd0,0,0);
`else
    // periodic reload of 2
    add(1,1,0, 4'd2, 4'd2,1,0);
    add(0,1,0, 4'd0, 4'd1,1,0);
    add(0,1,0, 4'd0, 4'd0,0,1);
    add(0,1,0, 4'd0, 4'd2,1,0);
    add(0,1,0, 4'd0, 4'd1,1,0);
    add(0,1,0, 4'd0, 4'd0,0,1);
    add(0,1,0, 4'd0, 4'd2,1,0);
    add(0,1,1, 4'd0, 4'd2,0,0);
    // reload of zero holds done high
    add(1,1,0, 4'd0, 4'd0,0,1);
    add(0,1,0, 4'd0, 4'd0,0,1);
    add(0,0,0, 4'd0, 4'd0,0,1);
    add(0,0,1, 4'd0, 4'd0,0,0);
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].en, vecs[i].sp, vecs[i].lv);
      step();
      check($sformatf("vec%0d", i), vecs[i].q, vecs[i].b, vecs[i].d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
